// File: rtl/am2910_pkg.sv
// am2910_pkg: shared opcode encodings and default stack depth for the am2910 sequencer
package am2910_pkg;
  localparam int STACK_DEPTH = 5;
  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;
endpackage

// File: rtl/am2910_stack.sv
// am2910_stack: subroutine/loop LIFO; a push when full overwrites the top, a pop when empty is ignored
module am2910_stack
  import am2910_pkg::*;
#(
  parameter int AW = 12,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);
  localparam int SW = $clog2(DEPTH + 1);
  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp;
  assign full  = sp == SW'(DEPTH);
  assign empty = sp == '0;
  assign top   = mem[empty ? '0 : sp - 1'b1];
  always_ff @(posedge cp) begin
    if (!rst_n || clr) sp <= '0;
    else if (push) begin
      mem[full ? SW'(DEPTH - 1) : sp] <= din;
      if (!full) sp <= sp + 1'b1;
    end else if (pop && !empty) sp <= sp - 1'b1;
  end
endmodule

// File: rtl/am2910_seq.sv
// am2910_seq: Am2910-compatible microprogram sequencer producing the next control-store address
module am2910_seq
  import am2910_pkg::*;
#(
  parameter int AW = 12,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic [3:0]    i,
  input  logic [AW-1:0] d,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          ci,
  input  logic          rld_n,
  input  logic          oe_n,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
);
  logic [AW-1:0] upc, r, stk_top, top, y_int;
  logic pass, rz, push, pop, clr, ld_r, dec_r, full, empty;
  assign pass = ccen_n | ~cc_n;
  assign rz   = r == '0;
  assign top  = empty ? '0 : stk_top;
  always_comb begin
    y_int = upc;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    ld_r  = 1'b0;
    dec_r = 1'b0;
    case (i)
      OP_JZ:          begin y_int = '0; clr = 1'b1; end
      OP_CJS:         begin y_int = pass ? d : upc; push = pass; end
      OP_JMAP:        y_int = d;
      OP_CJP, OP_CJV: y_int = pass ? d : upc;
      OP_PUSH:        begin push = 1'b1; ld_r = pass; end
      OP_JSRP:        begin y_int = pass ? d : r; push = 1'b1; end
      OP_JRP:         y_int = pass ? d : r;
      OP_RFCT:        begin y_int = rz ? upc : top; dec_r = ~rz; pop = rz; end
      OP_RPCT:        begin y_int = rz ? upc : d; dec_r = ~rz; end
      OP_CRTN:        begin y_int = pass ? top : upc; pop = pass; end
      OP_CJPP:        begin y_int = pass ? d : upc; pop = pass; end
      OP_LDCT:        ld_r = 1'b1;
      OP_LOOP:        begin y_int = pass ? upc : top; pop = pass; end
      OP_TWB:         begin y_int = pass ? upc : (rz ? d : top); pop = pass | rz; dec_r = ~pass & ~rz; end
      default:        ;
    endcase
    if (!rst_n) y_int = '0;
  end
  // external rld_n load wins over any opcode load or count
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      upc <= '0;
      r   <= '0;
    end else begin
      upc <= y_int + AW'(ci);
      r   <= (!rld_n || ld_r) ? d : (dec_r ? r - 1'b1 : r);
    end
  end
  am2910_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .cp(cp), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr),
    .din(upc), .top(stk_top), .full(full), .empty(empty)
  );
  assign y      = oe_n ? 'z : y_int;
  assign map_n  = !(rst_n && i == OP_JMAP);
  assign vect_n = !(rst_n && i == OP_CJV);
  assign pl_n   = !(map_n && vect_n);
  assign full_n = !(rst_n && full);
endmodule
